mdu_unit: RTL and testbench

//   Multiply/divide unit downstream of the register file: consumes the two

---
 rtl/mdu_unit_if.sv | 23 ++
 rtl/mdu_unit.sv | 134 +++++++++++++
 tb/tb_mdu_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_unit_if.sv
// Operand/result bundle between the register file, the MDU and the write-data mux.
// The master side issues operations; the slave side is the MDU.
interface mdu_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_sel;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] rd_data;

    modport master (
        output start, op, A, B, rd_sel,
        input  busy, HI, LO, rd_data
    );

    modport slave (
        input  start, op, A, B, rd_sel,
        output busy, HI, LO, rd_data
    );
endinterface

// File: rtl/mdu_unit.sv
// Multiply/divide unit holding HI/LO; results are computed at issue and retired
// into HI/LO after a fixed busy period so the controller can stall dependents.
module mdu_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_unit_if.slave   bus
);
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [31:0]        hi_reg;
    logic [31:0]        lo_reg;
    logic [31:0]        shadow_hi_reg;
    logic [31:0]        shadow_lo_reg;

    op_t                op_in;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        res_hi_next;
    logic [31:0]        res_lo_next;

    assign op_in = op_t'(bus.op);

    always_comb begin
        a_s         = $signed(bus.A);
        b_s         = $signed(bus.B);
        prod_s      = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
        prod_u      = {32'd0, bus.A} * {32'd0, bus.B};
        res_hi_next = '0;
        res_lo_next = '0;
        case (op_in)
            OP_MULT:  {res_hi_next, res_lo_next} = prod_s;
            OP_MULTU: {res_hi_next, res_lo_next} = prod_u;
            OP_DIV: begin
                // Zero divisor and the single overflowing quotient get fixed results.
                if (bus.B == 32'd0) begin
                    res_lo_next = 32'hFFFF_FFFF;
                    res_hi_next = bus.A;
                end else if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
                    res_lo_next = 32'h8000_0000;
                    res_hi_next = 32'd0;
                end else begin
                    res_lo_next = a_s / b_s;
                    res_hi_next = a_s % b_s;
                end
            end
            OP_DIVU: begin
                if (bus.B == 32'd0) begin
                    res_lo_next = 32'hFFFF_FFFF;
                    res_hi_next = bus.A;
                end else begin
                    res_lo_next = bus.A / bus.B;
                    res_hi_next = bus.A % bus.B;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            shadow_hi_reg <= '0;
            shadow_lo_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (op_in)
                            OP_MULT, OP_MULTU: begin
                                shadow_hi_reg <= res_hi_next;
                                shadow_lo_reg <= res_lo_next;
                                cnt_reg       <= CNT_W'(MUL_CYCLES);
                                state_reg     <= ST_BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
                                shadow_hi_reg <= res_hi_next;
                                shadow_lo_reg <= res_lo_next;
                                cnt_reg       <= CNT_W'(DIV_CYCLES);
                                state_reg     <= ST_BUSY;
                            end
                            OP_MTHI: hi_reg <= bus.A;
                            OP_MTLO: lo_reg <= bus.A;
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    // Last busy edge retires the shadow result; start is ignored here.
                    if (cnt_reg <= CNT_W'(1)) begin
                        hi_reg    <= shadow_hi_reg;
                        lo_reg    <= shadow_lo_reg;
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = (state_reg == ST_BUSY);
    assign bus.HI      = hi_reg;
    assign bus.LO      = lo_reg;
    assign bus.rd_data = bus.rd_sel ? hi_reg : lo_reg;
endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: vector table through a scoreboard, random MULTU/DIVU,
// plus start-while-busy, back-to-back and mid-divide reset sequences.
module tb_mdu_unit;
    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mdu_unit_if bus ();

    mdu_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks  = 0;
    int          errors  = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_regs(input string name, input logic [31:0] hi, input logic [31:0] lo);
        check32({name, ".HI"}, bus.HI, hi);
        check32({name, ".LO"}, bus.LO, lo);
        bus.rd_sel = 1'b0;
        #1 check32({name, ".rd_lo"}, bus.rd_data, lo);
        bus.rd_sel = 1'b1;
        #1 check32({name, ".rd_hi"}, bus.rd_data, hi);
        bus.rd_sel = 1'b0;
    endtask

    // Issue at a negedge, count busy cycles (bounded), then score the retired result.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                          input int cyc);
        exp_t e;
        int   n;
        e = '{name, hi, lo, cyc};
        sb.push_back(e);
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'd0;
        if (cyc > 0) begin
            check32({name, ".hold_HI"}, bus.HI, model_hi);
            check32({name, ".hold_LO"}, bus.LO, model_lo);
        end
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        e = sb.pop_front();
        check_int({e.name, ".busy_cycles"}, n, e.cyc);
        check_regs(e.name, e.hi, e.lo);
        $display("op %-10s op=%0d A=%08h B=%08h -> HI=%08h LO=%08h busy_cycles=%0d",
                 e.name, op, a, b, bus.HI, bus.LO, n);
        model_hi = e.hi;
        model_lo = e.lo;
    endtask

    vec_t vecs [14];

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] p;
        int          n;

        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.A      = 32'd0;
        bus.B      = 32'd0;
        bus.rd_sel = 1'b0;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_N};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, MUL_N};
        vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
        vecs[3]  = '{3'd4, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF, DIV_N};
        vecs[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_N};
        vecs[5]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_N};
        vecs[6]  = '{3'd4, 32'hFFFF_FFFF, 32'd10,       32'h0000_0005, 32'h1999_9999, DIV_N};
        vecs[7]  = '{3'd3, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, DIV_N};
        vecs[8]  = '{3'd5, 32'hDEAD_BEEF, 32'd9,        32'hDEAD_BEEF, 32'hFFFF_FFFF, 0};
        vecs[9]  = '{3'd6, 32'h1234_5678, 32'd9,        32'hDEAD_BEEF, 32'h1234_5678, 0};
        vecs[10] = '{3'd0, 32'd1,         32'd1,        32'hDEAD_BEEF, 32'h1234_5678, 0};
        vecs[11] = '{3'd7, 32'd2,         32'd2,        32'hDEAD_BEEF, 32'h1234_5678, 0};
        vecs[12] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_N};
        vecs[13] = '{3'd2, 32'h1234_5678, 32'd0,        32'h0000_0000, 32'h0000_0000, MUL_N};

        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_regs("reset", 32'd0, 32'd0);
        check32("reset.busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].cyc);
        end

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            p  = {32'd0, ra} * {32'd0, rb};
            run_op($sformatf("rmultu%0d", i), 3'd2, ra, rb, p[63:32], p[31:0], MUL_N);
            rb = 32'($urandom_range(1, 1000));
            run_op($sformatf("rdivu%0d", i), 3'd4, ra, rb, ra % rb, ra / rb, DIV_N);
        end

        // MULT issued, then MTHI held on start: ignored while busy and at the
        // retiring edge, accepted one edge later.
        bus.op = 3'd1; bus.A = 32'd3; bus.B = 32'd4; bus.start = 1'b1;
        @(negedge clk);
        bus.op = 3'd5; bus.A = 32'd5;
        check32("ignore.hold_HI", bus.HI, model_hi);
        check32("ignore.hold_LO", bus.LO, model_lo);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_int("ignore.busy_cycles", n, MUL_N);
        check_regs("ignore.mult", 32'd0, 32'd12);
        $display("seq ignore     MULT 3*4 with MTHI held: HI=%08h LO=%08h busy_cycles=%0d", bus.HI, bus.LO, n);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'd0;
        check_regs("b2b.mthi", 32'd5, 32'd12);
        check32("b2b.busy", {31'd0, bus.busy}, 32'd0);
        $display("seq b2b        MTHI after retire: HI=%08h LO=%08h", bus.HI, bus.LO);

        // Asynchronous reset in the third busy cycle of a divide.
        bus.op = 3'd3; bus.A = 32'hFFFF_FFF9; bus.B = 32'd2; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'd0;
        repeat (2) @(negedge clk);
        check32("abort.busy_before", {31'd0, bus.busy}, 32'd1);
        reset = 1'b0;
        #1;
        check32("abort.busy", {31'd0, bus.busy}, 32'd0);
        check32("abort.HI", bus.HI, 32'd0);
        check32("abort.LO", bus.LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check_regs("abort.later", 32'd0, 32'd0);
        check32("abort.later_busy", {31'd0, bus.busy}, 32'd0);
        $display("seq abort      DIV reset mid-op: HI=%08h LO=%08h busy=%0d", bus.HI, bus.LO, bus.busy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
